// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract: one CW-bit chunk per stage, carry rippling
// through pipeline registers, valid/ready handshake with full-pipeline stall.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CW = WIDTH / STAGES;

  // r_*[k] holds the operation waiting to be processed by stage k
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;

  logic [WIDTH-1:0]  w_s [STAGES];
  logic [STAGES-1:0] w_co;
  logic [CW:0]       w_add;
  logic              w_stall;

  assign w_stall  = out_valid && !out_ready;
  assign in_ready = rst || !w_stall;

  // Per-stage chunk adder: merges the new chunk into the partial sum
  always_comb begin
    w_add = '0;
    w_co  = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_add = {1'b0, r_a[k][k*CW +: CW]} + {1'b0, r_b[k][k*CW +: CW]}
            + (CW+1)'(r_c[k]);
      w_s[k]              = r_s[k];
      w_s[k][k*CW +: CW]  = w_add[CW-1:0];
      w_co[k]             = w_add[CW];
    end
  end

  // Pipeline advance; everything holds while the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v       <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (!w_stall) begin
      r_v[0] <= in_valid;
      r_a[0] <= a;
      r_b[0] <= sub ? ~b : b;
      r_s[0] <= '0;
      r_c[0] <= sub;
      for (int k = 1; k < STAGES; k++) begin
        r_v[k] <= r_v[k-1];
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
        r_s[k] <= w_s[k-1];
        r_c[k] <= w_co[k-1];
      end
      out_valid <= r_v[STAGES-1];
      out       <= w_s[STAGES-1];
      cout      <= w_co[STAGES-1];
      ovf       <= (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1]) &&
                   (w_s[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);
      zero      <= (w_s[STAGES-1] == '0);
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: 32-bit/4-stage main instance plus
// 8-bit instances with 1, 2 and 8 stages checked against an arithmetic model.
module tb_pipelined_adder;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a, b, out;
  logic        cout, ovf, zero;

  logic        v8, s8;
  logic [7:0]  a8, b8;
  logic        rdy8 [3];
  logic        ov8  [3];
  logic [7:0]  o8   [3];
  logic        c8   [3];
  logic        f8   [3];
  logic        z8   [3];

  int total, bad;
  int lat, acc, del, j;
  int sw [3];
  logic [7:0] va [1000];
  logic [7:0] vb [1000];
  logic       vs [1000];
  logic [7:0] eb;
  logic [8:0] r9;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cout(cout), .ovf(ovf), .zero(zero));

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8[0]),
    .a(a8), .b(b8), .sub(s8), .out_valid(ov8[0]), .out_ready(1'b1),
    .out(o8[0]), .cout(c8[0]), .ovf(f8[0]), .zero(z8[0]));

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8[1]),
    .a(a8), .b(b8), .sub(s8), .out_valid(ov8[1]), .out_ready(1'b1),
    .out(o8[1]), .cout(c8[1]), .ovf(f8[1]), .zero(z8[1]));

  pipelined_adder #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8[2]),
    .a(a8), .b(b8), .sub(s8), .out_valid(ov8[2]), .out_ready(1'b1),
    .out(o8[2]), .cout(c8[2]), .ovf(f8[2]), .zero(z8[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                       input logic [31:0] eo, input logic ec, input logic ef,
                       input logic ez);
    a = ia; b = ib; sub = is; in_valid = 1'b1;
    #1;
    chk("op_in_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 12);
    chk("op_latency", 64'(lat), 64'(4));
    chk("op_out", 64'(out), 64'(eo));
    chk("op_cout", 64'(cout), 64'(ec));
    chk("op_ovf", 64'(ovf), 64'(ef));
    chk("op_zero", 64'(zero), 64'(ez));
    tick();
    chk("op_drained", 64'(out_valid), 64'(0));
  endtask

  initial begin
    total = 0; bad = 0;
    sw[0] = 1; sw[1] = 2; sw[2] = 8;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;

    // Reset state
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out", 64'(out), 64'(0));
    chk("rst_flags", 64'({cout, ovf, zero}), 64'(0));
    chk("rst_ov8", 64'({ov8[0], ov8[1], ov8[2]}), 64'(0));
    tick();
    rst = 1'b0;

    // Directed single operations
    do_op(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    do_op(32'h0000_0003, 32'h0000_0003, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    do_op(32'h1234_5678, 32'h0000_FFFF, 1'b0, 32'h1235_5677, 1'b0, 1'b0, 1'b0);

    // Streaming with backpressure in cycles 6..9
    acc = 0; del = 0;
    for (int t = 0; t < 30; t++) begin
      in_valid  = (acc < 8);
      a         = 32'(acc);
      b         = 32'(acc * 16);
      sub       = 1'b0;
      out_ready = !(t >= 6 && t <= 9);
      #1;
      if (t < 12) chk("strm_in_ready", 64'(in_ready), 64'(!(t >= 6 && t <= 9)));
      if (out_valid && out_ready) begin
        chk("strm_out", 64'(out), 64'(del * 17));
        del++;
      end
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("strm_accepted", 64'(acc), 64'(8));
    chk("strm_delivered", 64'(del), 64'(8));
    chk("strm_idle", 64'(out_valid), 64'(0));

    // Reset mid-flight discards three in-flight ops and one offered in reset
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'(100 + i); b = '0; sub = 1'b0;
      tick();
    end
    rst = 1'b1; a = 32'd9; b = 32'd9;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mid_rst_no_stale", 64'(out_valid), 64'(0));
    end
    do_op(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);

    // 8-bit sweep: STAGES = 1, 2, 8 against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      va[i] = 8'($urandom);
      vb[i] = 8'($urandom);
      vs[i] = 1'($urandom);
    end
    for (int t = 0; t < 1010; t++) begin
      if (t < 1000) begin
        v8 = 1'b1; a8 = va[t]; b8 = vb[t]; s8 = vs[t];
      end else begin
        v8 = 1'b0;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        j = t - sw[d] - 1;
        chk("sw_in_ready", 64'(rdy8[d]), 64'(1));
        chk("sw_valid", 64'(ov8[d]), 64'(j >= 0 && j < 1000));
        if (j >= 0 && j < 1000) begin
          eb = vs[j] ? ~vb[j] : vb[j];
          r9 = {1'b0, va[j]} + {1'b0, eb} + 9'(vs[j]);
          chk("sw_sum", 64'({c8[d], o8[d]}), 64'(r9));
          chk("sw_ovf", 64'(f8[d]),
              64'((va[j][7] == eb[7]) && (r9[7] != va[j][7])));
          chk("sw_zero", 64'(z8[d]), 64'(r9[7:0] == 8'd0));
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
